// File: rtl/sp_ram_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// sp_ram_ctrl_pkg
// Shared types and constants for the sp_ram initiator (sp_ram_ctrl).
//   state_t  : controller state (idle / clear engine running)
//   RD_LAT   : cycles from request accept to read-response pulse
//   rd_tag_t : per-stage tag of the read-tracking shift register
// ---------------------------------------------------------------------------
package sp_ram_ctrl_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_t;

    // Accept edge -> RAM sample edge -> read-data capture edge.
    localparam int RD_LAT = 2;

    // One in-flight request slot: vld marks a read, err marks out-of-range.
    typedef struct packed {
        logic vld;
        logic err;
    } rd_tag_t;

endpackage

// File: rtl/sp_ram_ctrl.sv
// ---------------------------------------------------------------------------
// sp_ram_ctrl
// Initiator for the sp_ram single-port RAM (cs/rnw/add/wr_data/rd_data).
// Accepts read/write requests on a valid/ready port, drives registered RAM
// strobes, captures read data and returns it on a one-cycle response pulse.
// A clear engine fills every valid RAM word with a programmable value.
//
// Ports
//   clk, rst                      clock, asynchronous active-high reset
//   req_valid/req_ready           request handshake (accepted when both high)
//   req_rnw, req_add, req_wr_data request fields (1 = read)
//   rsp_valid, rsp_data, rsp_err  read response, fixed RD_LAT after accept
//   clr_start, clr_value          start a clear; fill value sampled with start
//   clr_done                      pulse on the edge issuing the last clear write
//   busy                          clear pending/active or read in flight
//   ram_cs, ram_rnw, ram_add,
//   ram_wr_data, ram_rd_data      sp_ram interface
// ---------------------------------------------------------------------------
module sp_ram_ctrl
    import sp_ram_ctrl_pkg::*;
#(
    parameter int add_wd  = 4,
    parameter int data_wd = 32,
    parameter int depth   = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic               req_rnw,
    input  logic [add_wd-1:0]  req_add,
    input  logic [data_wd-1:0] req_wr_data,
    output logic               rsp_valid,
    output logic [data_wd-1:0] rsp_data,
    output logic               rsp_err,
    input  logic               clr_start,
    input  logic [data_wd-1:0] clr_value,
    output logic               clr_done,
    output logic               busy,
    output logic               ram_cs,
    output logic               ram_rnw,
    output logic [add_wd-1:0]  ram_add,
    output logic [data_wd-1:0] ram_wr_data,
    input  logic [data_wd-1:0] ram_rd_data
);

    localparam logic [add_wd-1:0] CNT_LAST = add_wd'(depth - 1);

    state_t                    state_q, state_d;
    logic [add_wd-1:0]         cnt_q, cnt_d;
    logic                      clr_pend_q, clr_pend_d;
    logic [data_wd-1:0]        clr_val_q, clr_val_d;
    rd_tag_t [RD_LAT-1:0]      tag_q, tag_d;

    logic                      ram_cs_q, ram_cs_d;
    logic                      ram_rnw_q, ram_rnw_d;
    logic [add_wd-1:0]         ram_add_q, ram_add_d;
    logic [data_wd-1:0]        ram_wr_data_q, ram_wr_data_d;
    logic                      rsp_valid_q, rsp_valid_d;
    logic [data_wd-1:0]        rsp_data_q, rsp_data_d;
    logic                      rsp_err_q, rsp_err_d;
    logic                      clr_done_q, clr_done_d;
    logic                      busy_q, busy_d;

    logic                      accept;
    logic                      in_range;
    logic                      rd_in_flight_q;
    logic                      rd_in_flight_d;

    // A pending or starting clear blocks new requests, so clr_start wins
    // over a request presented in the same cycle.
    assign req_ready = (state_q == ST_IDLE) && !clr_pend_q && !clr_start;
    assign accept    = req_valid && req_ready;
    assign in_range  = int'(req_add) < depth;

    always_comb begin
        rd_in_flight_q = 1'b0;
        for (int i = 0; i < RD_LAT; i++) begin
            rd_in_flight_q = rd_in_flight_q | tag_q[i].vld;
        end
    end

    always_comb begin
        // NOTE: every _d gets a default first so no path can infer a latch.
        state_d       = state_q;
        cnt_d         = cnt_q;
        clr_pend_d    = clr_pend_q;
        clr_val_d     = clr_val_q;
        ram_cs_d      = 1'b0;
        ram_rnw_d     = ram_rnw_q;
        ram_add_d     = ram_add_q;
        ram_wr_data_d = ram_wr_data_q;
        rsp_valid_d   = 1'b0;
        rsp_data_d    = rsp_data_q;
        rsp_err_d     = 1'b0;
        clr_done_d    = 1'b0;

        // Read tracking: a tag enters at the accept edge and reaches the
        // last stage exactly when the RAM's read data is on ram_rd_data.
        tag_d[0] = '0;
        for (int i = RD_LAT - 1; i > 0; i--) begin
            tag_d[i] = tag_q[i-1];
        end
        if (tag_q[RD_LAT-1].vld) begin
            rsp_valid_d = 1'b1;
            rsp_err_d   = tag_q[RD_LAT-1].err;
            rsp_data_d  = tag_q[RD_LAT-1].err ? '0 : ram_rd_data;
        end

        if (clr_start && !clr_pend_q && state_q == ST_IDLE) begin
            clr_pend_d = 1'b1;
            clr_val_d  = clr_value;
        end

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    tag_d[0].vld = req_rnw;
                    tag_d[0].err = !in_range;
                    // Out-of-range requests never reach the RAM.
                    if (in_range) begin
                        ram_cs_d      = 1'b1;
                        ram_rnw_d     = req_rnw;
                        ram_add_d     = req_add;
                        ram_wr_data_d = req_wr_data;
                    end
                end else if (clr_pend_q && !rd_in_flight_q) begin
                    state_d = ST_CLEAR;
                end
            end
            ST_CLEAR: begin
                ram_cs_d      = 1'b1;
                ram_rnw_d     = 1'b0;
                ram_add_d     = cnt_q;
                ram_wr_data_d = clr_val_q;
                if (cnt_q == CNT_LAST) begin
                    cnt_d      = '0;
                    clr_done_d = 1'b1;
                    clr_pend_d = 1'b0;
                    state_d    = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + add_wd'(1);
                end
            end
            default: ;
        endcase

        rd_in_flight_d = 1'b0;
        for (int i = 0; i < RD_LAT; i++) begin
            rd_in_flight_d = rd_in_flight_d | tag_d[i].vld;
        end
        busy_d = clr_pend_d || (state_d == ST_CLEAR) || rd_in_flight_d;
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // flop samples the pre-edge value of every other flop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            cnt_q         <= '0;
            clr_pend_q    <= 1'b0;
            clr_val_q     <= '0;
            tag_q         <= '0;
            ram_cs_q      <= 1'b0;
            ram_rnw_q     <= 1'b1;
            ram_add_q     <= '0;
            ram_wr_data_q <= '0;
            rsp_valid_q   <= 1'b0;
            rsp_data_q    <= '0;
            rsp_err_q     <= 1'b0;
            clr_done_q    <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            clr_pend_q    <= clr_pend_d;
            clr_val_q     <= clr_val_d;
            tag_q         <= tag_d;
            ram_cs_q      <= ram_cs_d;
            ram_rnw_q     <= ram_rnw_d;
            ram_add_q     <= ram_add_d;
            ram_wr_data_q <= ram_wr_data_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_data_q    <= rsp_data_d;
            rsp_err_q     <= rsp_err_d;
            clr_done_q    <= clr_done_d;
            busy_q        <= busy_d;
        end
    end

    assign ram_cs      = ram_cs_q;
    assign ram_rnw     = ram_rnw_q;
    assign ram_add     = ram_add_q;
    assign ram_wr_data = ram_wr_data_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_data    = rsp_data_q;
    assign rsp_err     = rsp_err_q;
    assign clr_done    = clr_done_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_sp_ram_ctrl.sv
// ---------------------------------------------------------------------------
// tb_sp_ram_ctrl
// Bench for sp_ram_ctrl. A behavioural single-port RAM answers the depth-16
// instance; a scoreboard (golden memory + queue of expected responses due
// RD_LAT cycles after each accepted read) checks every response. A second
// instance with depth 12 exercises out-of-range handling.
// ---------------------------------------------------------------------------
module tb_sp_ram_ctrl;

    localparam int AW      = 4;
    localparam int DW      = 32;
    localparam int DEPTH   = 16;
    localparam int DEPTH12 = 12;
    localparam logic [DW-1:0] RD12_CONST = 32'hCAFE_F00D;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // depth-16 instance
    logic          req_valid, req_ready, req_rnw;
    logic [AW-1:0] req_add;
    logic [DW-1:0] req_wr_data;
    logic          rsp_valid, rsp_err;
    logic [DW-1:0] rsp_data;
    logic          clr_start, clr_done, busy;
    logic [DW-1:0] clr_value;
    logic          ram_cs, ram_rnw;
    logic [AW-1:0] ram_add;
    logic [DW-1:0] ram_wr_data, ram_rd_data;

    // depth-12 instance
    logic          r12_valid, r12_ready, r12_rnw;
    logic [AW-1:0] r12_add;
    logic [DW-1:0] r12_wr_data;
    logic          r12_rsp_valid, r12_rsp_err, r12_clr_done, r12_busy;
    logic [DW-1:0] r12_rsp_data;
    logic          r12_ram_cs, r12_ram_rnw;
    logic [AW-1:0] r12_ram_add;
    logic [DW-1:0] r12_ram_wr_data;
    logic          r12_clr_start;
    logic [DW-1:0] r12_clr_value;

    sp_ram_ctrl #(.add_wd(AW), .data_wd(DW), .depth(DEPTH)) u_dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_rnw(req_rnw),
        .req_add(req_add), .req_wr_data(req_wr_data),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err),
        .clr_start(clr_start), .clr_value(clr_value), .clr_done(clr_done),
        .busy(busy),
        .ram_cs(ram_cs), .ram_rnw(ram_rnw), .ram_add(ram_add),
        .ram_wr_data(ram_wr_data), .ram_rd_data(ram_rd_data)
    );

    sp_ram_ctrl #(.add_wd(AW), .data_wd(DW), .depth(DEPTH12)) u_dut12 (
        .clk(clk), .rst(rst),
        .req_valid(r12_valid), .req_ready(r12_ready), .req_rnw(r12_rnw),
        .req_add(r12_add), .req_wr_data(r12_wr_data),
        .rsp_valid(r12_rsp_valid), .rsp_data(r12_rsp_data), .rsp_err(r12_rsp_err),
        .clr_start(r12_clr_start), .clr_value(r12_clr_value), .clr_done(r12_clr_done),
        .busy(r12_busy),
        .ram_cs(r12_ram_cs), .ram_rnw(r12_ram_rnw), .ram_add(r12_ram_add),
        .ram_wr_data(r12_ram_wr_data), .ram_rd_data(RD12_CONST)
    );

    // Behavioural sp_ram: samples strobes on the edge, registered read data.
    logic [DW-1:0] mem [0:DEPTH-1];
    always @(posedge clk) begin
        if (ram_cs) begin
            if (ram_rnw) ram_rd_data <= mem[ram_add];
            else         mem[ram_add] <= ram_wr_data;
        end
    end

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [DW-1:0] act,
                         input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- scoreboard / monitor ----------------
    typedef struct {
        int            due;
        logic [DW-1:0] data;
        logic          err;
    } exp_t;

    exp_t          exp_q[$];
    exp_t          mon_e;
    logic [DW-1:0] ref_mem [0:DEPTH-1];
    int            cyc = 0;
    int            last_rsp_cyc = -1;
    int            clr_done_cnt = 0;
    int            wr_log[$];
    int            wr_cyc[$];

    always @(posedge clk) begin
        cyc++;
        if (rst) begin
            exp_q.delete();
        end else begin
            if (ram_cs && !ram_rnw) begin
                wr_log.push_back(int'(ram_add));
                wr_cyc.push_back(cyc);
            end
            if (req_valid && req_ready) begin
                if (req_rnw) begin
                    mon_e.due  = cyc + 2;
                    mon_e.err  = int'(req_add) >= DEPTH;
                    mon_e.data = mon_e.err ? '0 : ref_mem[req_add];
                    exp_q.push_back(mon_e);
                end else if (int'(req_add) < DEPTH) begin
                    ref_mem[req_add] = req_wr_data;
                end
            end
        end
        #1;
        if (!rst) begin
            if (clr_done) clr_done_cnt++;
            if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
                check("sb_rsp_valid", {31'b0, rsp_valid}, 1);
                check("sb_rsp_data", rsp_data, exp_q[0].data);
                check("sb_rsp_err", {31'b0, rsp_err}, {31'b0, exp_q[0].err});
                last_rsp_cyc = cyc;
                void'(exp_q.pop_front());
            end else if (rsp_valid) begin
                check("sb_unexpected_rsp", {31'b0, rsp_valid}, 0);
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // ---------------- vector tables ----------------
    typedef struct {
        logic          rnw;
        logic [AW-1:0] add;
        logic [DW-1:0] wdata;
        logic          exp_vld;
        logic [DW-1:0] exp_data;
        logic          exp_err;
    } vec_t;

    vec_t vecs[32];

    typedef struct {
        logic          rnw;
        logic [AW-1:0] add;
        logic          exp_cs;
        logic          exp_rsp;
        logic [DW-1:0] exp_data;
        logic          exp_err;
    } v12_t;

    v12_t v12[5];

    task automatic wait_clr_done(input string name);
        int n = 0;
        while (!clr_done && n < 60) begin
            tick();
            n++;
        end
        check(name, {31'b0, clr_done}, 1);
    endtask

    initial begin
        int acc_cyc;
        logic ok;

        rst = 1'b1;
        req_valid = 0; req_rnw = 0; req_add = '0; req_wr_data = '0;
        clr_start = 0; clr_value = '0;
        r12_valid = 0; r12_rnw = 0; r12_add = '0; r12_wr_data = '0;
        r12_clr_start = 0; r12_clr_value = '0;
        ram_rd_data = '0;
        for (int i = 0; i < DEPTH; i++) begin
            mem[i] = '0;
            ref_mem[i] = '0;
        end

        for (int i = 0; i < 32; i++) begin
            if (i < 16) vecs[i] = '{1'b0, AW'(i), DW'(i * 32'h11), 1'b0, '0, 1'b0};
            else        vecs[i] = '{1'b1, AW'(i - 16), '0, 1'b1, DW'((i - 16) * 32'h11), 1'b0};
        end
        v12[0] = '{1'b1, 4'd15, 1'b0, 1'b1, 32'h0, 1'b1};
        v12[1] = '{1'b1, 4'd12, 1'b0, 1'b1, 32'h0, 1'b1};
        v12[2] = '{1'b1, 4'd11, 1'b1, 1'b1, RD12_CONST, 1'b0};
        v12[3] = '{1'b0, 4'd12, 1'b0, 1'b0, 32'h0, 1'b0};
        v12[4] = '{1'b0, 4'd11, 1'b1, 1'b0, 32'h0, 1'b0};

        // ---- reset state ----
        repeat (3) tick();
        check("rst_ram_cs", {31'b0, ram_cs}, 0);
        check("rst_ram_rnw", {31'b0, ram_rnw}, 1);
        check("rst_ram_add", {28'b0, ram_add}, 0);
        check("rst_ram_wr_data", ram_wr_data, 0);
        check("rst_rsp_valid", {31'b0, rsp_valid}, 0);
        check("rst_rsp_data", rsp_data, 0);
        check("rst_rsp_err", {31'b0, rsp_err}, 0);
        check("rst_clr_done", {31'b0, clr_done}, 0);
        check("rst_busy", {31'b0, busy}, 0);
        rst = 1'b0;
        tick();
        check("post_rst_req_ready", {31'b0, req_ready}, 1);

        // ---- write 0xDEADBEEF @3 then read @3 ----
        req_valid = 1; req_rnw = 0; req_add = 4'd3; req_wr_data = 32'hDEAD_BEEF;
        tick();
        check("wr_ram_cs", {31'b0, ram_cs}, 1);
        check("wr_ram_rnw", {31'b0, ram_rnw}, 0);
        check("wr_ram_add", {28'b0, ram_add}, 3);
        check("wr_ram_wr_data", ram_wr_data, 32'hDEAD_BEEF);
        req_rnw = 1;
        tick();
        req_valid = 0;
        check("rd_ram_cs", {31'b0, ram_cs}, 1);
        check("rd_ram_rnw", {31'b0, ram_rnw}, 1);
        check("rd_busy", {31'b0, busy}, 1);
        check("rd_n0_rsp_valid", {31'b0, rsp_valid}, 0);
        tick();
        check("rd_n1_rsp_valid", {31'b0, rsp_valid}, 0);
        check("rd_n1_ram_cs_idle", {31'b0, ram_cs}, 0);
        check("rd_n1_ram_add_hold", {28'b0, ram_add}, 3);
        tick();
        check("rd_n2_rsp_valid", {31'b0, rsp_valid}, 1);
        check("rd_n2_rsp_data", rsp_data, 32'hDEAD_BEEF);
        check("rd_n2_rsp_err", {31'b0, rsp_err}, 0);
        tick();
        check("rd_n3_rsp_valid", {31'b0, rsp_valid}, 0);
        check("rd_n3_busy", {31'b0, busy}, 0);

        // ---- table: 16 writes then 16 back-to-back reads ----
        for (int i = 0; i < 34; i++) begin
            if (i < 32) begin
                req_valid = 1; req_rnw = vecs[i].rnw;
                req_add = vecs[i].add; req_wr_data = vecs[i].wdata;
            end else begin
                req_valid = 0;
            end
            tick();
            if (i >= 2) begin
                check($sformatf("vec%0d_rsp_valid", i - 2), {31'b0, rsp_valid},
                      {31'b0, vecs[i-2].exp_vld});
                if (vecs[i-2].exp_vld) begin
                    check($sformatf("vec%0d_rsp_data", i - 2), rsp_data, vecs[i-2].exp_data);
                    check($sformatf("vec%0d_rsp_err", i - 2), {31'b0, rsp_err},
                          {31'b0, vecs[i-2].exp_err});
                end
            end
        end
        tick();

        // ---- depth-12 instance: out-of-range handling ----
        for (int k = 0; k < 5; k++) begin
            r12_valid = 1; r12_rnw = v12[k].rnw; r12_add = v12[k].add;
            r12_wr_data = 32'h1111_0000 + DW'(k);
            tick();
            r12_valid = 0;
            check($sformatf("d12_%0d_ram_cs", k), {31'b0, r12_ram_cs}, {31'b0, v12[k].exp_cs});
            tick();
            check($sformatf("d12_%0d_ram_cs_idle", k), {31'b0, r12_ram_cs}, 0);
            tick();
            check($sformatf("d12_%0d_rsp_valid", k), {31'b0, r12_rsp_valid},
                  {31'b0, v12[k].exp_rsp});
            if (v12[k].exp_rsp) begin
                check($sformatf("d12_%0d_rsp_data", k), r12_rsp_data, v12[k].exp_data);
                check($sformatf("d12_%0d_rsp_err", k), {31'b0, r12_rsp_err},
                      {31'b0, v12[k].exp_err});
            end
        end

        // ---- randomized traffic against the scoreboard ----
        for (int i = 0; i < 400; i++) begin
            req_valid   = ($urandom_range(0, 9) < 7);
            req_rnw     = $urandom_range(0, 1) == 1;
            req_add     = AW'($urandom_range(0, DEPTH - 1));
            req_wr_data = $urandom;
            tick();
        end
        req_valid = 0;
        repeat (4) tick();
        check("rand_drained", DW'(exp_q.size()), 0);

        // ---- clr_start beats a same-cycle request ----
        wr_log.delete(); wr_cyc.delete(); clr_done_cnt = 0;
        clr_start = 1; clr_value = 32'hA5A5_A5A5;
        req_valid = 1; req_rnw = 1; req_add = 4'd5;
        #1;
        check("clr_req_ready_low", {31'b0, req_ready}, 0);
        tick();
        clr_start = 0; req_valid = 0;
        check("clr_busy", {31'b0, busy}, 1);
        wait_clr_done("clr_done_seen");
        tick();
        check("clr_done_one_cycle", {31'b0, clr_done}, 0);
        tick();
        check("clr_done_count", DW'(clr_done_cnt), 1);
        check("clr_write_count", DW'(wr_log.size()), 16);
        ok = (wr_log.size() == 16);
        for (int i = 0; i < wr_log.size(); i++) begin
            if (wr_log[i] != i || wr_cyc[i] != wr_cyc[0] + i) ok = 0;
        end
        check("clr_write_order", {31'b0, ok}, 1);
        check("clr_idle_busy", {31'b0, busy}, 0);
        check("clr_idle_ready", {31'b0, req_ready}, 1);
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = 32'hA5A5_A5A5;
        for (int i = 0; i < DEPTH; i++) begin
            req_valid = 1; req_rnw = 1; req_add = AW'(DEPTH - 1 - i);
            tick();
        end
        req_valid = 0;
        repeat (3) tick();
        check("clr_readback_drained", DW'(exp_q.size()), 0);

        // ---- clr_start while a read is in flight ----
        req_valid = 1; req_rnw = 0; req_add = 4'd7; req_wr_data = 32'h1234_5678;
        tick();
        req_rnw = 1;
        tick();
        acc_cyc = cyc;
        req_valid = 0;
        wr_log.delete(); wr_cyc.delete(); clr_done_cnt = 0;
        clr_start = 1; clr_value = 32'h5A5A_5A5A;
        tick();
        clr_start = 0;
        check("inflight_busy", {31'b0, busy}, 1);
        wait_clr_done("inflight_clr_done_seen");
        tick();
        check("inflight_rsp_cycle", DW'(last_rsp_cyc), DW'(acc_cyc + 2));
        check("inflight_write_count", DW'(wr_log.size()), 16);
        check("inflight_clear_after_rsp", {31'b0, (wr_cyc.size() > 0) && (wr_cyc[0] > last_rsp_cyc)}, 1);
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = 32'h5A5A_5A5A;
        req_valid = 1; req_rnw = 1; req_add = 4'd7;
        tick();
        req_add = 4'd0;
        tick();
        req_valid = 0;
        repeat (3) tick();

        // ---- reset in the middle of a clear ----
        clr_done_cnt = 0;
        clr_start = 1; clr_value = 32'h0F0F_0F0F;
        tick();
        clr_start = 0;
        begin
            int n = 0;
            while (!(ram_cs && !ram_rnw && ram_add == 4'd7) && n < 40) begin
                tick();
                n++;
            end
            check("mid_clear_reached_cnt7", {31'b0, ram_cs && ram_add == 4'd7}, 1);
        end
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_ram_cs", {31'b0, ram_cs}, 0);
        check("async_rst_ram_rnw", {31'b0, ram_rnw}, 1);
        check("async_rst_ram_add", {28'b0, ram_add}, 0);
        check("async_rst_ram_wr_data", ram_wr_data, 0);
        check("async_rst_busy", {31'b0, busy}, 0);
        check("async_rst_clr_done", {31'b0, clr_done}, 0);
        repeat (2) tick();
        rst = 1'b0;
        #1;
        check("post_abort_req_ready", {31'b0, req_ready}, 1);
        repeat (20) tick();
        check("post_abort_no_clr_done", DW'(clr_done_cnt), 0);
        check("post_abort_ram_cs", {31'b0, ram_cs}, 0);
        check("post_abort_busy", {31'b0, busy}, 0);
        check("post_abort_req_ready_late", {31'b0, req_ready}, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
